sbox_sequencer: RTL
===================

# sbox_sequencer

Sequencer that runs a full 128-bit SubBytes or InvSubBytes pass through one shared byte-wide S-box unit. The shared unit is the GF(2^8) inverter plus the forward or inverse affine stage. The block accepts a state word over a valid/ready handshake, issues its 16 bytes to the S-box one per cycle, and collects the results. It tolerates a configurable S-box pipeline latency and returns the substituted state over a second valid/ready handshake. It sits between the round controller and the single shared S-box instance, so encrypt and decrypt share one substitution datapath.

## Interface
Parameters:
- SBOX_LAT, 1: cycles from `sb_in` presented to `sb_out` valid. Legal range is 0–4; 0 means a combinational S-box.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input state offered
- in_ready  out  1  block can accept a state
- in_state  in  128  state to substitute; byte k = in_state[8k+7:8k]
- in_inv  in  1  0 = SubBytes (forward), 1 = InvSubBytes
- out_valid  out  1  substituted state available
- out_ready  in  1  consumer accepts out_state
- out_state  out  128  substituted state, same byte ordering
- busy  out  1  high whenever state ≠ IDLE
- sb_req  out  1  byte issued to the S-box this cycle
- sb_in  out  8  byte to the S-box
- sb_inv  out  1  S-box direction select
- sb_out  in  8  S-box result, valid SBOX_LAT cycles after the matching sb_req

## Operation
- FSM states are IDLE, ISSUE, DRAIN and DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_state and in_inv, clear both counters, and go to ISSUE.
  - ISSUE: issue counter i runs 0..15. Drive sb_req=1 and sb_in = latched byte i. After i=15, go to DRAIN, or go directly to DONE when the final byte is also collected that cycle (SBOX_LAT=0).
  - DRAIN: sb_req=0. Wait until the collect counter has captured byte 15, then go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Capture path:
  - A SBOX_LAT-deep shift register carries the sb_req tag.
  - When the delayed tag is set, write sb_out into out_state byte c, where c is the collect counter, then increment c.
  - Bytes are collected in issue order.
- sb_inv equals the latched in_inv for the whole operation, including DRAIN.
- sb_in = 8'h00 whenever sb_req=0.
- in_ready = (state==IDLE) && !rst. There is no overlap between operations; in_valid outside IDLE is ignored.
- out_state holds stable while out_valid && !out_ready. It keeps its last value after the DONE handshake, until the next collection starts overwriting bytes.
- The block does not inspect or modify byte values; all substitution arithmetic lives in the S-box.

## Timing
- Cycle 0 is the cycle in which in_valid&&in_ready is sampled.
- Byte k is driven on sb_in in cycle k+1, for k=0..15.
- Result k is captured at the end of cycle k+1+SBOX_LAT.
- out_valid first asserts in cycle 17+SBOX_LAT. This gives 18 cycles for SBOX_LAT=1 and 17 cycles for SBOX_LAT=0.
- If out_ready is high in that cycle, in_ready returns in the next cycle. Minimum initiation interval is 18+SBOX_LAT cycles.
- Reset values (the cycle after rst is sampled high): state=IDLE, out_valid=0, out_state=0, busy=0, sb_req=0, sb_in=0, sb_inv=0, counters=0, tag pipe cleared. in_ready=0 while rst is high and 1 afterwards.
- Reset mid-operation, in any state, abandons the operation. In-flight S-box results are discarded and no partial out_valid is produced.
- A simultaneous rst and in_valid is not accepted.
- A simultaneous out_ready and in_valid while in DONE: only the output handshake completes, and the input is accepted no earlier than the next IDLE cycle.

## Test plan
- Bench S-box model with SBOX_LAT=1, forward mode, in_state=128'h0f0e0d0c0b0a09080706050403020100. Required: out_state=128'h76abd7fe2b670130c56f6bf27b777c63, out_valid first high in cycle 18, and sb_in sequence 00,01,…,0f in cycles 1–16.
- Inverse mode, SBOX_LAT=0, in_state=all 8'h63 except byte 5=8'hED. Required: out_state=all 8'h00 except byte 5=8'h53, out_valid in cycle 17, and sb_inv=1 throughout.
- SBOX_LAT=4, forward, in_state=0. Required: out_state=all 8'h63, out_valid in cycle 21, and sb_req low during DRAIN cycles 17–20.
- Hold out_ready low for 5 cycles in DONE. Required: out_state stable and out_valid held. Drive in_valid high throughout; in_ready must stay 0 and no second operation may start.
- Assert rst in cycle 9 of an operation. Required the next cycle: IDLE, out_valid=0, out_state=0, sb_req=0. Then run a new operation; its result must be correct, with no stale bytes from the aborted pass.
- Back-to-back operations with out_ready tied high. Required: second acceptance exactly one cycle after the first output handshake, and both results correct.

Source files
------------

// File: rtl/sbox_sequencer.sv
// Streams a 128-bit state through one shared byte-wide S-box and reassembles the result.
// Bytes go out one per cycle and come back in issue order, SBOX_LAT cycles later.
module sbox_sequencer #(
   parameter int SBOX_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy,
   output logic         sb_req,
   output logic [7:0]   sb_in,
   output logic         sb_inv,
   input  logic [7:0]   sb_out
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t       state_q, state_d;
   logic [127:0] data_q, data_d;
   logic [127:0] out_state_q, out_state_d;
   logic         inv_q, inv_d;
   logic [3:0]   issue_cnt_q, issue_cnt_d;
   logic [3:0]   coll_cnt_q, coll_cnt_d;
   logic         tag_out;
   logic         last_coll;

   // The request tag rides alongside the S-box pipeline so each result is captured exactly once.
   if (SBOX_LAT == 0) begin : g_tag_comb
      assign tag_out = sb_req;
   end else begin : g_tag_pipe
      logic [SBOX_LAT-1:0] tag_q, tag_d;
      logic [SBOX_LAT:0]   tag_sh;

      always_comb begin
         tag_sh = {tag_q, sb_req};
         tag_d  = tag_sh[SBOX_LAT-1:0];
      end

      always_ff @(posedge clk) begin
         if (rst) tag_q <= '0;
         else     tag_q <= tag_d;
      end

      assign tag_out = tag_q[SBOX_LAT-1];
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign busy      = (state_q != IDLE);
   assign sb_req    = (state_q == ISSUE);
   assign sb_in     = sb_req ? data_q[{issue_cnt_q, 3'b000} +: 8] : 8'h00;
   assign sb_inv    = inv_q;
   assign out_valid = (state_q == DONE);
   assign out_state = out_state_q;
   assign last_coll = tag_out && (coll_cnt_q == 4'd15);

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      inv_d       = inv_q;
      issue_cnt_d = issue_cnt_q;
      coll_cnt_d  = coll_cnt_q;
      out_state_d = out_state_q;

      if (tag_out) begin
         out_state_d[{coll_cnt_q, 3'b000} +: 8] = sb_out;
         coll_cnt_d = coll_cnt_q + 4'd1;
      end

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d      = in_state;
               inv_d       = in_inv;
               issue_cnt_d = 4'd0;
               coll_cnt_d  = 4'd0;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            issue_cnt_d = issue_cnt_q + 4'd1;
            if (issue_cnt_q == 4'd15) state_d = last_coll ? DONE : DRAIN;
         end
         DRAIN: begin
            if (last_coll) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         inv_q       <= 1'b0;
         issue_cnt_q <= 4'd0;
         coll_cnt_q  <= 4'd0;
         out_state_q <= '0;
      end else begin
         state_q     <= state_d;
         inv_q       <= inv_d;
         issue_cnt_q <= issue_cnt_d;
         coll_cnt_q  <= coll_cnt_d;
         out_state_q <= out_state_d;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

endmodule
